apb_master_arbiter: RTL and testbench

Multi-requester APB master for the DTC verification environment and RTL shell. It accepts single-beat read/write requests from NUM_REQ independent requesters and arbitrates them round-robin. It sequences the winner through the APB SETUP and ACCESS phases on one shared APB bus, and returns the read data and error status to the requester that issued the transfer. It sits between the internal register-access sources and the APB slave bus sampled by the apb_slave agent.

---
 rtl/apb_master_arbiter.sv | 177 +++++++++++++++++
 tb/tb_apb_master_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter
// Round-robin arbiter plus single-beat APB master shared by NUM_REQ requesters.
// The winner is sequenced through SETUP and ACCESS on one APB bus, and its
// completion (read data, error) is returned as a one-cycle rsp_valid pulse.
// Optional feature: define APB_ARB_TIMEOUT_EN to abort ACCESS phases that wait
// TIMEOUT_CYCLES cycles for pready; the aborted transfer reports rsp_err = 1.
module apb_master_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  pclk,
  input  logic                  preset_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ-1:0]    req_write,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  input  logic [NUM_REQ*DW-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [DW-1:0]         rsp_rdata,
  output logic                  rsp_err,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [AW-1:0]         paddr,
  output logic [DW-1:0]         pwdata,
  input  logic [DW-1:0]         prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  localparam int IW = $clog2(NUM_REQ);

  // Elaboration-time guards on the legal parameter ranges.
  if (NUM_REQ < 2 || NUM_REQ > 4) begin : g_bad_num_req
    $error("apb_master_arbiter: NUM_REQ must be in 2..4");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("apb_master_arbiter: TIMEOUT_CYCLES must be in 1..255");
  end

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   owner;
  logic [IW-1:0]   win;
  logic            any_req;
  logic            access_done;
  logic            grant_en;
  logic            sel_write;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;

  // First requester with valid set, searching from the pointer upward (mod NUM_REQ).
  function automatic logic [IW-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                            input logic [IW-1:0]      p);
    logic [IW-1:0] w;
    int            idx;
    w = p;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(p) + k) % NUM_REQ;
      if (v[idx]) w = IW'(idx);
    end
    return w;
  endfunction

  // Pointer value after a grant to w: the requester just above w becomes top priority.
  function automatic logic [IW-1:0] rr_next(input logic [IW-1:0] w);
    return IW'((int'(w) + 1) % NUM_REQ);
  endfunction

`ifdef APB_ARB_TIMEOUT_EN
  logic [7:0] tcnt;
  logic       timeout_hit;

  // Timeout fires on the ACCESS wait cycle that brings the count to TIMEOUT_CYCLES.
  always_comb begin
    timeout_hit = (state == ACCESS) && !pready && (tcnt == 8'(TIMEOUT_CYCLES - 1));
  end
`endif

  // Grant decision and combinational accept strobe; a grant is only possible when the bus is free.
  always_comb begin
    win         = rr_pick(req_valid, ptr);
    any_req     = |req_valid;
    access_done = (state == ACCESS) && pready;
    grant_en    = any_req && ((state == IDLE) || access_done);
    sel_write   = req_write[win];
    sel_addr    = req_addr[int'(win)*AW +: AW];
    sel_wdata   = req_wdata[int'(win)*DW +: DW];
    req_ready   = '0;
    if (grant_en) req_ready[win] = 1'b1;
  end

  // Transfer FSM with registered APB and response outputs.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state     <= IDLE;
      ptr       <= '0;
      owner     <= '0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
      tcnt      <= '0;
`endif
    end else begin
      rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (grant_en) begin
            pwrite  <= sel_write;
            paddr   <= sel_addr;
            pwdata  <= sel_wdata;
            owner   <= win;
            ptr     <= rr_next(win);
            psel    <= 1'b1;
            penable <= 1'b0;
            state   <= SETUP;
          end
        end
        SETUP: begin
          penable <= 1'b1;
          state   <= ACCESS;
`ifdef APB_ARB_TIMEOUT_EN
          tcnt    <= '0;
`endif
        end
        ACCESS: begin
          if (pready) begin
            rsp_valid[owner] <= 1'b1;
            rsp_rdata        <= pwrite ? '0 : prdata;
            rsp_err          <= pslverr;
            penable          <= 1'b0;
            if (grant_en) begin
              // Back-to-back: psel stays high, next transfer goes straight to SETUP.
              pwrite <= sel_write;
              paddr  <= sel_addr;
              pwdata <= sel_wdata;
              owner  <= win;
              ptr    <= rr_next(win);
              state  <= SETUP;
            end else begin
              psel  <= 1'b0;
              state <= IDLE;
            end
          end
`ifdef APB_ARB_TIMEOUT_EN
          else if (timeout_hit) begin
            rsp_valid[owner] <= 1'b1;
            rsp_rdata        <= '0;
            rsp_err          <= 1'b1;
            psel             <= 1'b0;
            penable          <= 1'b0;
            state            <= IDLE;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
`endif
        end
        default: begin
          psel    <= 1'b0;
          penable <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Testbench for apb_master_arbiter: directed scenarios followed by a randomized
// run checked against a transfer-level protocol model.
module tb_apb_master_arbiter;

  localparam int N       = 2;
  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int TIMEOUT = 16;

  logic            pclk;
  logic            preset_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_write;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err;
  logic            psel;
  logic            penable;
  logic            pwrite;
  logic [AW-1:0]   paddr;
  logic [DW-1:0]   pwdata;
  logic [DW-1:0]   prdata;
  logic            pready;
  logic            pslverr;

  int checks;
  int failures;

  apb_master_arbiter #(
    .NUM_REQ(N), .AW(AW), .DW(DW), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .pclk(pclk), .preset_n(preset_n),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]            = 1'b1;
    req_write[i]            = wr;
    req_addr[i*AW +: AW]    = a;
    req_wdata[i*DW +: DW]   = d;
  endtask

  task automatic do_reset();
    preset_n  = 1'b0;
    req_valid = '0;
    pready    = 1'b0;
    pslverr   = 1'b0;
    tick();
    tick();
    preset_n  = 1'b1;
  endtask

  // Random-phase model state
  int              ptr_m;
  int              phase;      // 0 none, 1 setup, 2 access
  int              cur_own;
  logic            cur_wr;
  logic [AW-1:0]   cur_addr;
  logic [DW-1:0]   cur_wd;
  logic [N-1:0]    exp_rsp;
  logic [DW-1:0]   exp_rd;
  logic            exp_err;
  logic [N-1:0]    exp_rdy;
  int              acc_w;
  logic            done;
  int              n_acc;

  initial begin
    checks    = 0;
    failures  = 0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    prdata    = '0;
    do_reset();

    // Reset values
    #1;
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_pwrite", pwrite, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_req_ready", req_ready, 0);

    // Single write, requester 0, zero wait states
    tick();
    set_req(0, 1'b1, 32'h10, 32'hA5A5_0001);
    pready = 1'b1;
    #1;
    chk("wr_ready_T", req_ready, 2'b01);
    tick();
    req_valid[0] = 1'b0;
    #1;
    chk("wr_setup_psel", psel, 1);
    chk("wr_setup_penable", penable, 0);
    chk("wr_setup_paddr", paddr, 32'h10);
    chk("wr_setup_pwdata", pwdata, 32'hA5A5_0001);
    chk("wr_setup_pwrite", pwrite, 1);
    tick();
    chk("wr_access_penable", penable, 1);
    chk("wr_access_paddr", paddr, 32'h10);
    chk("wr_access_rsp_valid", rsp_valid, 0);
    tick();
    chk("wr_rsp_valid", rsp_valid, 2'b01);
    chk("wr_rsp_err", rsp_err, 0);
    chk("wr_rsp_rdata", rsp_rdata, 0);
    chk("wr_done_psel", psel, 0);

    // Read, requester 1, three wait states
    set_req(1, 1'b0, 32'h24, 32'h0);
    pready = 1'b0;
    #1;
    chk("rd_ready_T", req_ready, 2'b10);
    tick();
    req_valid[1] = 1'b0;
    #1;
    chk("rd_setup_penable", penable, 0);
    chk("rd_setup_pwrite", pwrite, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k == 3) begin
        pready = 1'b1;
        prdata = 32'h1234_5678;
      end
      #1;
      chk("rd_access_penable", penable, 1);
      chk("rd_access_paddr", paddr, 32'h24);
      chk("rd_access_rsp_valid", rsp_valid, 0);
    end
    tick();
    pready = 1'b0;
    #1;
    chk("rd_rsp_valid", rsp_valid, 2'b10);
    chk("rd_rsp_rdata", rsp_rdata, 32'h1234_5678);
    chk("rd_rsp_err", rsp_err, 0);
    chk("rd_done_psel", psel, 0);

    // Both requesters held valid from reset: grants 0,1,0,1 back to back
    do_reset();
    set_req(0, 1'b1, 32'h100, 32'h0);
    set_req(1, 1'b1, 32'h200, 32'h1);
    pready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      #1;
      chk("b2b_grant", req_ready, (t % 2 == 0) ? 2'b01 : 2'b10);
      tick();
      if (t == 3) req_valid = '0;
      #1;
      chk("b2b_setup_psel", psel, 1);
      chk("b2b_setup_penable", penable, 0);
      chk("b2b_setup_paddr", paddr, (t % 2 == 0) ? 32'h100 : 32'h200);
      chk("b2b_prev_rsp", rsp_valid, (t == 0) ? 2'b00 : ((t % 2 == 1) ? 2'b01 : 2'b10));
      tick();
      chk("b2b_access_penable", penable, 1);
    end
    tick();
    chk("b2b_last_rsp", rsp_valid, 2'b10);
    chk("b2b_idle_psel", psel, 0);

    // pslverr on a write reports error only for that transfer
    set_req(0, 1'b1, 32'h30, 32'hDEAD);
    pready  = 1'b1;
    pslverr = 1'b1;
    #1;
    chk("err_ready0", req_ready, 2'b01);
    tick();
    req_valid[0] = 1'b0;
    tick();
    tick();
    chk("err_rsp_valid0", rsp_valid, 2'b01);
    chk("err_rsp_err0", rsp_err, 1);
    pslverr = 1'b0;
    set_req(1, 1'b1, 32'h34, 32'hBEEF);
    #1;
    chk("err_ready1", req_ready, 2'b10);
    tick();
    req_valid[1] = 1'b0;
    tick();
    tick();
    chk("err_rsp_valid1", rsp_valid, 2'b10);
    chk("err_rsp_err1", rsp_err, 0);

    // Reset during ACCESS aborts the transfer and restarts the pointer at 0
    set_req(0, 1'b0, 32'h40, 32'h0);
    pready = 1'b0;
    #1;
    chk("abort_ready", req_ready, 2'b01);
    tick();
    req_valid[0] = 1'b0;
    tick();
    chk("abort_in_access", penable, 1);
    preset_n = 1'b0;
    #1;
    chk("abort_psel", psel, 0);
    chk("abort_penable", penable, 0);
    chk("abort_paddr", paddr, 0);
    chk("abort_rsp_valid", rsp_valid, 0);
    tick();
    tick();
    preset_n = 1'b1;
    pready   = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("abort_no_rsp", rsp_valid, 0);
      chk("abort_idle_psel", psel, 0);
    end
    set_req(0, 1'b1, 32'h44, 32'h5);
    set_req(1, 1'b1, 32'h48, 32'h6);
    #1;
    chk("abort_ptr0", req_ready, 2'b01);
    tick();
    req_valid[0] = 1'b0;
    tick();
    chk("abort_next_ready", req_ready, 2'b10);
    tick();
    req_valid[1] = 1'b0;
    #1;
    chk("abort_next_paddr", paddr, 32'h48);
    tick();
    tick();
    chk("abort_next_rsp", rsp_valid, 2'b10);

`ifdef APB_ARB_TIMEOUT_EN
    // Stuck pready terminates after TIMEOUT wait cycles
    set_req(0, 1'b0, 32'h50, 32'h0);
    pready = 1'b0;
    prdata = 32'hFFFF_FFFF;
    #1;
    chk("to_ready", req_ready, 2'b01);
    tick();
    req_valid[0] = 1'b0;
    tick();
    n_acc = 0;
    for (int k = 0; k < 40; k++) begin
      if (penable !== 1'b1) break;
      n_acc++;
      tick();
    end
    chk("to_len", n_acc, TIMEOUT);
    chk("to_rsp_valid", rsp_valid, 2'b01);
    chk("to_rsp_err", rsp_err, 1);
    chk("to_rsp_rdata", rsp_rdata, 0);
    chk("to_psel", psel, 0);
    tick();
    chk("to_idle_psel", psel, 0);
    chk("to_idle_rsp", rsp_valid, 0);
`endif

    // Randomized run against the transfer-level model
    do_reset();
    ptr_m   = 0;
    phase   = 0;
    cur_own = 0;
    cur_wr  = 1'b0;
    cur_addr = '0;
    cur_wd  = '0;
    exp_rsp = '0;
    exp_rd  = '0;
    exp_err = 1'b0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0)
          set_req(i, 1'($urandom_range(0, 1)), $urandom, $urandom);
      end
      pready  = ($urandom_range(0, 3) != 0);
      prdata  = $urandom;
      pslverr = ($urandom_range(0, 5) == 0);
      #1;
      chk("rnd_psel", psel, phase != 0);
      chk("rnd_penable", penable, phase == 2);
      if (phase != 0) begin
        chk("rnd_paddr", paddr, cur_addr);
        chk("rnd_pwrite", pwrite, cur_wr);
        chk("rnd_pwdata", pwdata, cur_wd);
      end
      chk("rnd_rsp_valid", rsp_valid, exp_rsp);
      if (exp_rsp != 0) begin
        chk("rnd_rsp_rdata", rsp_rdata, exp_rd);
        chk("rnd_rsp_err", rsp_err, exp_err);
      end
      done    = (phase == 2) && pready;
      exp_rdy = '0;
      acc_w   = -1;
      if ((phase == 0 || done) && req_valid != 0) begin
        for (int k = 0; k < N; k++) begin
          if (acc_w < 0 && req_valid[(ptr_m + k) % N]) acc_w = (ptr_m + k) % N;
        end
        exp_rdy[acc_w] = 1'b1;
      end
      chk("rnd_req_ready", req_ready, exp_rdy);
      exp_rsp = '0;
      if (done) begin
        exp_rsp[cur_own] = 1'b1;
        exp_rd  = cur_wr ? '0 : prdata;
        exp_err = pslverr;
      end
      if (acc_w >= 0) begin
        cur_own  = acc_w;
        cur_wr   = req_write[acc_w];
        cur_addr = req_addr[acc_w*AW +: AW];
        cur_wd   = req_wdata[acc_w*DW +: DW];
        ptr_m    = (acc_w + 1) % N;
        phase    = 1;
      end else if (done) begin
        phase = 0;
      end else if (phase == 1) begin
        phase = 2;
      end
      tick();
      if (acc_w >= 0) req_valid[acc_w] = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
